dispatch_unit: RTL and testbench



---
 rtl/dispatch_unit.sv | 163 ++++++++++++++++
 tb/tb_dispatch_unit.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_unit.sv
// dispatch_unit: single-issue dispatch stage behind the 1-entry dispatch FIFO.
// Each cycle it accepts at most one renamed instruction, allocates a ROB entry
// and writes the instruction into the ALU, LSU or BRU reservation station.
// It also owns the physical-register busy table. Bits are set when an
// instruction that writes a destination dispatches, and cleared by writeback
// broadcasts. A writeback in the same cycle bypasses into the ready bits.
// Optional feature macro: DISPATCH_STALL_CNT_EN adds saturating 32-bit stall
// counters, stall_rob_cnt and stall_rs_cnt.

package ooop_types;
    localparam int PREG_W = 7;

    typedef struct packed {
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
        logic              rd_we;
        logic [1:0]        fu_type;
    } rename_pkt_t;
endpackage

module dispatch_unit #(
    parameter int NPREG     = 128,
    parameter int NWB       = 3,
    parameter int ROB_IDX_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  ooop_types::rename_pkt_t       in_pkt,
    input  logic                          rob_alloc_ready,
    input  logic [ROB_IDX_W-1:0]          rob_alloc_idx,
    output logic                          rob_alloc_valid,
    output logic [2:0]                    rs_valid,
    input  logic [2:0]                    rs_ready,
    output ooop_types::rename_pkt_t       rs_pkt,
    output logic                          rs_src1_rdy,
    output logic                          rs_src2_rdy,
    output logic [ROB_IDX_W-1:0]          rs_rob_idx,
    input  logic [NWB-1:0]                wb_valid,
    input  logic [NWB*$clog2(NPREG)-1:0]  wb_preg
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_rob_cnt,
    output logic [31:0]                   stall_rs_cnt
`endif
);

    localparam int PREG_W = $clog2(NPREG);

    // fu_type encoding
    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_LSU = 2'd1;
    localparam logic [1:0] FU_BRU = 2'd2;

    logic [NPREG-1:0] busy;
    logic [NPREG-1:0] busy_nxt;
    logic [NPREG-1:0] wb_clr;
    logic             rs_sel_rdy;
    logic             fire;
    logic             src1_byp;
    logic             src2_byp;

    // Free-slot indication of the RS selected by fu_type; illegal type never ready
    always_comb begin
        rs_sel_rdy = 1'b0;
        case (in_pkt.fu_type)
            FU_ALU:  rs_sel_rdy = rs_ready[0];
            FU_LSU:  rs_sel_rdy = rs_ready[1];
            FU_BRU:  rs_sel_rdy = rs_ready[2];
            default: rs_sel_rdy = 1'b0;
        endcase
    end

    assign fire = in_valid && rob_alloc_ready && rs_sel_rdy && !flush_i;

    // Same-cycle writeback bypass match against both source tags
    always_comb begin
        src1_byp = 1'b0;
        src2_byp = 1'b0;
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i] && (wb_preg[i*PREG_W +: PREG_W] == in_pkt.prs1)) begin
                src1_byp = 1'b1;
            end
            if (wb_valid[i] && (wb_preg[i*PREG_W +: PREG_W] == in_pkt.prs2)) begin
                src2_byp = 1'b1;
            end
        end
    end

    // Decode writeback tags into a clear mask; duplicate tags simply overlap
    always_comb begin
        wb_clr = '0;
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i]) begin
                wb_clr[wb_preg[i*PREG_W +: PREG_W]] = 1'b1;
            end
        end
    end

    // Next busy table: clear on writeback, then a dispatching destination sets
    // (so a set wins over a same-cycle clear); entry 0 is held at zero
    always_comb begin
        busy_nxt = busy & ~wb_clr;
        if (fire && in_pkt.rd_we && (in_pkt.prd != '0)) begin
            busy_nxt[in_pkt.prd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy table register: reset over flush over normal update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush_i) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Dispatch outputs are purely combinational; zero-latency handshake
    always_comb begin
        in_ready        = fire;
        rob_alloc_valid = fire;
        rs_valid        = 3'b000;
        if (fire) begin
            rs_valid = 3'b001 << in_pkt.fu_type;
        end
        rs_pkt      = in_pkt;
        rs_rob_idx  = rob_alloc_idx;
        rs_src1_rdy = !busy[in_pkt.prs1] || src1_byp;
        rs_src2_rdy = !busy[in_pkt.prs2] || src2_byp;
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign stall = in_valid && !flush_i && !fire;

    // Stall attribution: ROB full takes precedence, everything else is the RS;
    // flush does not clear these
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_rob_cnt <= 32'd0;
            stall_rs_cnt  <= 32'd0;
        end else if (stall) begin
            if (!rob_alloc_ready) begin
                stall_rob_cnt <= sat_inc(stall_rob_cnt);
            end else begin
                stall_rs_cnt <= sat_inc(stall_rs_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed scenarios plus randomized traffic for
// dispatch_unit, checked against a set-based busy-table reference model.
// Build with DISPATCH_STALL_CNT_EN defined to also check the stall counters.

module tb_dispatch_unit;

    localparam int NPREG     = 128;
    localparam int NWB       = 3;
    localparam int ROB_IDX_W = 5;
    localparam int PW        = 7;

    logic                    clk;
    logic                    rst_n;
    logic                    flush_i;
    logic                    in_valid;
    logic                    in_ready;
    ooop_types::rename_pkt_t in_pkt;
    logic                    rob_alloc_ready;
    logic [ROB_IDX_W-1:0]    rob_alloc_idx;
    logic                    rob_alloc_valid;
    logic [2:0]              rs_valid;
    logic [2:0]              rs_ready;
    ooop_types::rename_pkt_t rs_pkt;
    logic                    rs_src1_rdy;
    logic                    rs_src2_rdy;
    logic [ROB_IDX_W-1:0]    rs_rob_idx;
    logic [NWB-1:0]          wb_valid;
    logic [NWB*PW-1:0]       wb_preg;
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0]             stall_rob_cnt;
    logic [31:0]             stall_rs_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dispatch_unit #(
        .NPREG(NPREG), .NWB(NWB), .ROB_IDX_W(ROB_IDX_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush_i(flush_i),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pkt(in_pkt),
        .rob_alloc_ready(rob_alloc_ready),
        .rob_alloc_idx(rob_alloc_idx),
        .rob_alloc_valid(rob_alloc_valid),
        .rs_valid(rs_valid),
        .rs_ready(rs_ready),
        .rs_pkt(rs_pkt),
        .rs_src1_rdy(rs_src1_rdy),
        .rs_src2_rdy(rs_src2_rdy),
        .rs_rob_idx(rs_rob_idx),
        .wb_valid(wb_valid),
        .wb_preg(wb_preg)
`ifdef DISPATCH_STALL_CNT_EN
        ,
        .stall_rob_cnt(stall_rob_cnt),
        .stall_rs_cnt(stall_rs_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          pending[NPREG];   // 1 = value not yet written back
    int unsigned m_rob_cnt;
    int unsigned m_rs_cnt;

    function automatic bit m_fire();
        if (!in_valid || !rob_alloc_ready || flush_i) return 1'b0;
        if (in_pkt.fu_type == 2'd3) return 1'b0;
        return rs_ready[in_pkt.fu_type];
    endfunction

    function automatic bit m_rdy(input logic [PW-1:0] tag);
        bit r;
        r = !pending[tag];
        for (int i = 0; i < NWB; i++)
            if (wb_valid[i] && wb_preg[i*PW +: PW] == tag) r = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] m_rsv();
        if (!m_fire()) return 3'b000;
        case (in_pkt.fu_type)
            2'd0: return 3'b001;
            2'd1: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    always @(posedge clk) begin
        bit f;
        f = m_fire();
        if (!rst_n) begin
            for (int k = 0; k < NPREG; k++) pending[k] = 1'b0;
            m_rob_cnt = 0;
            m_rs_cnt  = 0;
        end else begin
            if (in_valid && !flush_i && !f) begin
                if (!rob_alloc_ready) begin
                    if (m_rob_cnt != 32'hFFFF_FFFF) m_rob_cnt++;
                end else begin
                    if (m_rs_cnt != 32'hFFFF_FFFF) m_rs_cnt++;
                end
            end
            if (flush_i) begin
                for (int k = 0; k < NPREG; k++) pending[k] = 1'b0;
            end else begin
                for (int i = 0; i < NWB; i++)
                    if (wb_valid[i]) pending[wb_preg[i*PW +: PW]] = 1'b0;
                if (f && in_pkt.rd_we && in_pkt.prd != 0) pending[in_pkt.prd] = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] fu, input logic [PW-1:0] s1,
                         input logic [PW-1:0] s2, input logic [PW-1:0] d, input bit we);
        in_valid       = v;
        in_pkt.fu_type = fu;
        in_pkt.prs1    = s1;
        in_pkt.prs2    = s2;
        in_pkt.prd     = d;
        in_pkt.rd_we   = we;
    endtask

    task automatic all_ready();
        rob_alloc_ready = 1'b1;
        rs_ready        = 3'b111;
        flush_i         = 1'b0;
        wb_valid        = '0;
        wb_preg         = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        all_ready();
        drive(1'b0, 2'd0, 7'd0, 7'd0, 7'd0, 1'b0);
        rob_alloc_idx = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (rob_alloc_valid !== 1'b0) begin errors++; $display("FAIL reset_rob_valid: got %b want 0", rob_alloc_valid); end
        checks++;
        if (rs_valid !== 3'b000) begin errors++; $display("FAIL reset_rs_valid: got %b want 000", rs_valid); end
`ifdef DISPATCH_STALL_CNT_EN
        checks++;
        if (stall_rob_cnt !== 32'd0 || stall_rs_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_rob_cnt, stall_rs_cnt);
        end
`endif
        next_cycle();
    endtask

    task automatic test_alu_dispatch();
        drive(1'b1, 2'd0, 7'd5, 7'd0, 7'd9, 1'b1);
        rob_alloc_idx = 5'd3;
        @(negedge clk);
        checks++;
        if (rs_valid !== 3'b001 || in_ready !== 1'b1 || rob_alloc_valid !== 1'b1) begin
            errors++; $display("FAIL alu_strobes: got rs_valid=%b in_ready=%b rob=%b want 001/1/1", rs_valid, in_ready, rob_alloc_valid);
        end
        checks++;
        if (rs_rob_idx !== 5'd3) begin errors++; $display("FAIL alu_rob_idx: got %0d want 3", rs_rob_idx); end
        checks++;
        if (rs_src1_rdy !== 1'b1 || rs_src2_rdy !== 1'b1) begin
            errors++; $display("FAIL alu_rdy: got %b%b want 11", rs_src1_rdy, rs_src2_rdy);
        end
        checks++;
        if (rs_pkt !== in_pkt) begin errors++; $display("FAIL alu_pkt: got %h want %h", rs_pkt, in_pkt); end
        next_cycle();
    endtask

    task automatic test_dependent_and_bypass();
        // Consumer right after producer, no writeback: not ready
        drive(1'b1, 2'd1, 7'd9, 7'd0, 7'd0, 1'b0);
        rob_alloc_idx = 5'd4;
        @(negedge clk);
        checks++;
        if (rs_valid !== 3'b010) begin errors++; $display("FAIL lsu_rs_valid: got %b want 010", rs_valid); end
        checks++;
        if (rs_src1_rdy !== 1'b0) begin errors++; $display("FAIL dep_src1_busy: got %b want 0", rs_src1_rdy); end
        next_cycle();
        // Same packet with tag 9 on writeback port 1: bypassed
        wb_valid = 3'b010;
        wb_preg  = '0;
        wb_preg[1*PW +: PW] = 7'd9;
        @(negedge clk);
        checks++;
        if (rs_src1_rdy !== 1'b1) begin errors++; $display("FAIL bypass_src1: got %b want 1", rs_src1_rdy); end
        next_cycle();
        wb_valid = '0;
        @(negedge clk);
        checks++;
        if (rs_src1_rdy !== 1'b1) begin errors++; $display("FAIL wb_cleared_src1: got %b want 1", rs_src1_rdy); end
        next_cycle();
    endtask

    task automatic test_rs_stall();
        drive(1'b1, 2'd2, 7'd1, 7'd2, 7'd0, 1'b0);
        rs_ready = 3'b011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || rs_valid !== 3'b000 || rob_alloc_valid !== 1'b0) begin
                errors++; $display("FAIL rs_stall_c%0d: got in_ready=%b rs_valid=%b rob=%b want 0/000/0", c, in_ready, rs_valid, rob_alloc_valid);
            end
            next_cycle();
        end
        rs_ready = 3'b111;
        @(negedge clk);
        checks++;
        if (rs_valid !== 3'b100 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bru_release: got rs_valid=%b in_ready=%b want 100/1", rs_valid, in_ready);
        end
`ifdef DISPATCH_STALL_CNT_EN
        checks++;
        if (stall_rs_cnt !== 32'd4) begin errors++; $display("FAIL stall_rs_cnt: got %0d want 4", stall_rs_cnt); end
`endif
        next_cycle();
    endtask

    task automatic test_rob_stall();
        drive(1'b1, 2'd0, 7'd1, 7'd2, 7'd0, 1'b0);
        rob_alloc_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || rs_valid !== 3'b000 || rob_alloc_valid !== 1'b0) begin
                errors++; $display("FAIL rob_stall_c%0d: got in_ready=%b rs_valid=%b rob=%b want 0/000/0", c, in_ready, rs_valid, rob_alloc_valid);
            end
            next_cycle();
        end
        rob_alloc_ready = 1'b1;
        @(negedge clk);
`ifdef DISPATCH_STALL_CNT_EN
        checks++;
        if (stall_rob_cnt !== 32'd2 || stall_rs_cnt !== 32'd4) begin
            errors++; $display("FAIL stall_rob_cnt: got %0d/%0d want 2/4", stall_rob_cnt, stall_rs_cnt);
        end
`endif
        checks++;
        if (rs_valid !== 3'b001) begin errors++; $display("FAIL rob_release: got %b want 001", rs_valid); end
        next_cycle();
    endtask

    task automatic test_illegal_fu();
        drive(1'b1, 2'd3, 7'd0, 7'd0, 7'd7, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || rs_valid !== 3'b000 || rob_alloc_valid !== 1'b0) begin
                errors++; $display("FAIL illegal_fu_c%0d: got in_ready=%b rs_valid=%b rob=%b want 0/000/0", c, in_ready, rs_valid, rob_alloc_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_set_wins_and_p0();
        drive(1'b1, 2'd0, 7'd0, 7'd0, 7'd12, 1'b1);
        wb_valid = 3'b001;
        wb_preg  = '0;
        wb_preg[0 +: PW] = 7'd12;
        next_cycle();
        wb_valid = '0;
        drive(1'b1, 2'd0, 7'd12, 7'd0, 7'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (rs_src1_rdy !== 1'b0) begin errors++; $display("FAIL set_wins_p12: got rdy=%b want 0", rs_src1_rdy); end
        next_cycle();
        drive(1'b1, 2'd1, 7'd3, 7'd0, 7'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (rs_src2_rdy !== 1'b1) begin errors++; $display("FAIL p0_never_busy: got rdy=%b want 1", rs_src2_rdy); end
        next_cycle();
    endtask

    task automatic test_back_to_back_flush();
        drive(1'b1, 2'd0, 7'd0, 7'd0, 7'd9, 1'b1);
        next_cycle();
        drive(1'b1, 2'd0, 7'd9, 7'd12, 7'd40, 1'b1);
        @(negedge clk);
        checks++;
        if (rs_valid !== 3'b001 || rs_src1_rdy !== 1'b0 || rs_src2_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b: got rs_valid=%b rdy=%b%b want 001/00", rs_valid, rs_src1_rdy, rs_src2_rdy);
        end
        next_cycle();
        flush_i = 1'b1;
        drive(1'b1, 2'd0, 7'd1, 7'd1, 7'd50, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || rs_valid !== 3'b000 || rob_alloc_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_fire: got in_ready=%b rs_valid=%b rob=%b want 0/000/0", in_ready, rs_valid, rob_alloc_valid);
        end
        next_cycle();
        flush_i = 1'b0;
        drive(1'b1, 2'd0, 7'd9, 7'd12, 7'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (rs_src1_rdy !== 1'b1 || rs_src2_rdy !== 1'b1) begin
            errors++; $display("FAIL flush_clears: got rdy=%b%b want 11", rs_src1_rdy, rs_src2_rdy);
        end
        drive(1'b1, 2'd0, 7'd40, 7'd50, 7'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (rs_src1_rdy !== 1'b1 || rs_src2_rdy !== 1'b1) begin
            errors++; $display("FAIL flush_clears_40_50: got rdy=%b%b want 11", rs_src1_rdy, rs_src2_rdy);
        end
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 2'd0, 7'd0, 7'd0, 7'd30, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 7'd30, 7'd0, 7'd31, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || rs_valid !== 3'b010) begin
            errors++; $display("FAIL reset_fire_eq: got in_ready=%b rs_valid=%b want 1/010", in_ready, rs_valid);
        end
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 7'd30, 7'd31, 7'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (rs_src1_rdy !== 1'b1 || rs_src2_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_clears_busy: got rdy=%b%b want 11", rs_src1_rdy, rs_src2_rdy);
        end
`ifdef DISPATCH_STALL_CNT_EN
        checks++;
        if (stall_rob_cnt !== 32'd0 || stall_rs_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_clears_cnt: got %0d/%0d want 0/0", stall_rob_cnt, stall_rs_cnt);
        end
`endif
        next_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n           = ($urandom_range(0, 99) != 0);
            flush_i         = ($urandom_range(0, 29) == 0);
            in_valid        = ($urandom_range(0, 9) < 8);
            in_pkt.prs1     = PW'($urandom_range(0, 15));
            in_pkt.prs2     = PW'($urandom_range(0, 15));
            in_pkt.prd      = PW'($urandom_range(0, 15));
            in_pkt.rd_we    = $urandom_range(0, 1) != 0;
            in_pkt.fu_type  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rob_alloc_ready = ($urandom_range(0, 9) < 8);
            rob_alloc_idx   = ROB_IDX_W'($urandom);
            rs_ready        = 3'($urandom) | 3'($urandom);
            wb_valid        = NWB'($urandom);
            for (int i = 0; i < NWB; i++) wb_preg[i*PW +: PW] = PW'($urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if (in_ready !== m_fire() || rob_alloc_valid !== m_fire() || rs_valid !== m_rsv()) begin
                errors++; $display("FAIL rnd_strobes_c%0d: got %b/%b/%b want %b/%b/%b", c, in_ready, rob_alloc_valid, rs_valid, m_fire(), m_fire(), m_rsv());
            end
            if (m_fire()) begin
                checks++;
                if (rs_src1_rdy !== m_rdy(in_pkt.prs1) || rs_src2_rdy !== m_rdy(in_pkt.prs2)) begin
                    errors++; $display("FAIL rnd_rdy_c%0d: got %b%b want %b%b", c, rs_src1_rdy, rs_src2_rdy, m_rdy(in_pkt.prs1), m_rdy(in_pkt.prs2));
                end
                checks++;
                if (rs_pkt !== in_pkt || rs_rob_idx !== rob_alloc_idx) begin
                    errors++; $display("FAIL rnd_payload_c%0d: got %h/%0d want %h/%0d", c, rs_pkt, rs_rob_idx, in_pkt, rob_alloc_idx);
                end
            end
`ifdef DISPATCH_STALL_CNT_EN
            checks++;
            if (stall_rob_cnt !== m_rob_cnt || stall_rs_cnt !== m_rs_cnt) begin
                errors++; $display("FAIL rnd_cnt_c%0d: got %0d/%0d want %0d/%0d", c, stall_rob_cnt, stall_rs_cnt, m_rob_cnt, m_rs_cnt);
            end
`endif
            next_cycle();
        end
        rst_n = 1'b1;
        all_ready();
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_dispatch();
        test_dependent_and_bypass();
        test_rs_stall();
        test_rob_stall();
        test_illegal_fu();
        test_set_wins_and_p0();
        test_back_to_back_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
